// File: rtl/router_reg_param_if.sv
// Packet byte stream between the router input, the register stage and the destination FIFOs.
interface router_reg_param_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2
);
    logic                  pkt_valid;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  fifo_full;
    logic                  busy;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  write_enb;
    logic [ADDR_BITS-1:0]  dest_addr;
    logic                  header_valid;
    logic                  parity_done;
    logic                  err;
    logic                  len_err;
    logic                  low_packet_valid;

    modport master (
        output pkt_valid, data_in, fifo_full,
        input  busy, data_out, write_enb, dest_addr, header_valid,
               parity_done, err, len_err, low_packet_valid
    );

    modport slave (
        input  pkt_valid, data_in, fifo_full,
        output busy, data_out, write_enb, dest_addr, header_valid,
               parity_done, err, len_err, low_packet_valid
    );
endinterface

// File: rtl/router_reg_param.sv
// Parametrised router packet register: header decode, FIFO back-pressure hold, parity check.
// Optional payload length check enabled by defining ROUTER_REG_LEN_CHECK_EN.
module router_reg_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_BITS  = 2,
    parameter int NUM_PORTS  = 3
) (
    input  logic               clock,
    input  logic               reset,
    router_reg_param_if.slave  bus
);
    localparam int LEN_BITS = DATA_WIDTH - ADDR_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FIRST,
        LOAD_DATA,
        HOLD,
        CHECK,
        DROP
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] header_q;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  hold_is_parity;
    logic [DATA_WIDTH-1:0] internal_parity;
    logic [DATA_WIDTH-1:0] packet_parity;
    logic                  addr_ok;
`ifdef ROUTER_REG_LEN_CHECK_EN
    logic [LEN_BITS-1:0]   count;
`endif

    assign addr_ok = (32'(bus.data_in[ADDR_BITS-1:0]) < $unsigned(NUM_PORTS));

    // busy is registered with the value belonging to the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= IDLE;
            header_q             <= '0;
            hold_data            <= '0;
            hold_is_parity       <= 1'b0;
            internal_parity      <= '0;
            packet_parity        <= '0;
`ifdef ROUTER_REG_LEN_CHECK_EN
            count                <= '0;
`endif
            bus.busy             <= 1'b0;
            bus.data_out         <= '0;
            bus.write_enb        <= 1'b0;
            bus.dest_addr        <= '0;
            bus.header_valid     <= 1'b0;
            bus.parity_done      <= 1'b0;
            bus.err              <= 1'b0;
            bus.len_err          <= 1'b0;
            bus.low_packet_valid <= 1'b0;
        end else begin
            bus.write_enb    <= 1'b0;
            bus.header_valid <= 1'b0;
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    if (bus.pkt_valid) begin
                        if (addr_ok) begin
                            header_q             <= bus.data_in;
                            bus.dest_addr        <= bus.data_in[ADDR_BITS-1:0];
                            bus.header_valid     <= 1'b1;
                            bus.parity_done      <= 1'b0;
                            bus.err              <= 1'b0;
                            bus.len_err          <= 1'b0;
                            bus.low_packet_valid <= 1'b0;
`ifdef ROUTER_REG_LEN_CHECK_EN
                            count                <= '0;
`endif
                            bus.busy             <= 1'b1;
                            state                <= LOAD_FIRST;
                        end else begin
                            state <= DROP;
                        end
                    end
                end

                LOAD_FIRST: begin
                    bus.data_out    <= header_q;
                    bus.write_enb   <= 1'b1;
                    internal_parity <= header_q;
                    bus.busy        <= 1'b0;
                    state           <= LOAD_DATA;
                end

                LOAD_DATA: begin
                    if (bus.fifo_full) begin
                        hold_data      <= bus.data_in;
                        hold_is_parity <= ~bus.pkt_valid;
                        bus.busy       <= 1'b1;
                        state          <= HOLD;
                    end else if (bus.pkt_valid) begin
                        bus.data_out    <= bus.data_in;
                        bus.write_enb   <= 1'b1;
                        internal_parity <= internal_parity ^ bus.data_in;
`ifdef ROUTER_REG_LEN_CHECK_EN
                        if (count != '1)
                            count <= count + 1'b1;
`endif
                    end else begin
                        bus.data_out         <= bus.data_in;
                        bus.write_enb        <= 1'b1;
                        packet_parity        <= bus.data_in;
                        bus.low_packet_valid <= 1'b1;
                        bus.busy             <= 1'b1;
                        state                <= CHECK;
                    end
                end

                HOLD: begin
                    if (!bus.fifo_full) begin
                        bus.data_out  <= hold_data;
                        bus.write_enb <= 1'b1;
                        if (hold_is_parity) begin
                            packet_parity        <= hold_data;
                            bus.low_packet_valid <= 1'b1;
                            state                <= CHECK;
                        end else begin
                            internal_parity <= internal_parity ^ hold_data;
`ifdef ROUTER_REG_LEN_CHECK_EN
                            if (count != '1)
                                count <= count + 1'b1;
`endif
                            bus.busy <= 1'b0;
                            state    <= LOAD_DATA;
                        end
                    end
                end

                CHECK: begin
                    bus.parity_done <= 1'b1;
                    bus.err         <= (internal_parity != packet_parity);
`ifdef ROUTER_REG_LEN_CHECK_EN
                    bus.len_err     <= (count != header_q[DATA_WIDTH-1:ADDR_BITS]);
`else
                    bus.len_err     <= 1'b0;
`endif
                    bus.busy        <= 1'b0;
                    state           <= IDLE;
                end

                DROP: begin
                    bus.busy <= 1'b0;
                    if (!bus.pkt_valid)
                        state <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_router_reg_param.sv
// Self-checking bench for router_reg_param: directed scenarios plus randomized packets vs. a packet-level model.
module tb_router_reg_param;
    localparam int DW     = 8;
    localparam int AB     = 2;
    localparam int NP     = 3;
    localparam int LB     = DW - AB;
    localparam int MAXLEN = (1 << LB) - 1;
`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam bit LEN_CHK = 1'b1;
`else
    localparam bit LEN_CHK = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    router_reg_param_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

    router_reg_param #(.DATA_WIDTH(DW), .ADDR_BITS(AB), .NUM_PORTS(NP)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write and header_valid monitor
    logic [DW-1:0] wr_q[$];
    int            hv_cnt;
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.write_enb)    wr_q.push_back(bus.data_out);
            if (bus.header_valid) hv_cnt++;
        end
    end

    // Reference state
    logic [DW-1:0] pay_q[$];
    logic [DW-1:0] exp_q[$];
    bit            exp_pd, exp_err, exp_lerr, exp_lpv;
    logic [AB-1:0] exp_addr;
    bit            rand_full;

    // Present one byte until the DUT takes it (busy low at the sampling edge)
    task automatic send_byte(input logic v, input logic [DW-1:0] d);
        int waited = 0;
        forever begin
            @(negedge clock);
            bus.pkt_valid = v;
            bus.data_in   = d;
            bus.fifo_full = rand_full ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (!bus.busy) begin
                @(posedge clock);
                return;
            end
            waited++;
            if (waited > 200) begin
                check_eq("send_timeout", waited, 0);
                return;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"},  bus.busy,             0);
        check_eq({tag, "_wen"},   bus.write_enb,        0);
        check_eq({tag, "_dout"},  bus.data_out,         0);
        check_eq({tag, "_addr"},  bus.dest_addr,        0);
        check_eq({tag, "_hv"},    bus.header_valid,     0);
        check_eq({tag, "_pd"},    bus.parity_done,      0);
        check_eq({tag, "_err"},   bus.err,              0);
        check_eq({tag, "_lerr"},  bus.len_err,          0);
        check_eq({tag, "_lpv"},   bus.low_packet_valid, 0);
    endtask

    task automatic check_writes(input string tag);
        check_eq({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
            check_eq({tag, "_wr_byte"}, wr_q[i], exp_q[i]);
    endtask

    task automatic finish_valid(input string tag, input bit e_err, input bit e_lerr);
        int t = 0;
        do begin
            @(negedge clock);
            bus.pkt_valid = 1'b0;
            bus.fifo_full = 1'b0;
            t++;
        end while (!bus.parity_done && t < 20);
        if (!bus.parity_done) check_eq({tag, "_pd_timeout"}, t, 0);
        check_eq({tag, "_pd"},   bus.parity_done,      1);
        check_eq({tag, "_err"},  bus.err,              e_err);
        check_eq({tag, "_lerr"}, bus.len_err,          e_lerr);
        check_eq({tag, "_lpv"},  bus.low_packet_valid, 1);
        check_eq({tag, "_addr"}, bus.dest_addr,        exp_addr);
        check_eq({tag, "_busy"}, bus.busy,             0);
        check_eq({tag, "_hv"},   hv_cnt,               1);
        check_writes(tag);
        exp_pd = 1'b1; exp_err = e_err; exp_lerr = e_lerr; exp_lpv = 1'b1;
    endtask

    // Send header, pay_q, and parity (force_par < 0 means correct parity)
    task automatic run_packet(input string tag, input int addr, input int len, input int force_par);
        logic [DW-1:0] hdr, good, par;
        int            cnt;
        bit            e_lerr;
        hdr  = {len[LB-1:0], addr[AB-1:0]};
        good = hdr;
        foreach (pay_q[i]) good ^= pay_q[i];
        par  = (force_par < 0) ? good : force_par[DW-1:0];
        cnt  = (pay_q.size() > MAXLEN) ? MAXLEN : pay_q.size();
        e_lerr = LEN_CHK && (cnt != len);
        wr_q.delete();
        hv_cnt = 0;

        send_byte(1'b1, hdr);
        if (addr < NP) begin
            exp_addr = addr[AB-1:0];
            @(negedge clock);
            check_eq({tag, "_hdr_hv"},   bus.header_valid,     1);
            check_eq({tag, "_hdr_addr"}, bus.dest_addr,        exp_addr);
            check_eq({tag, "_hdr_pd"},   bus.parity_done,      0);
            check_eq({tag, "_hdr_err"},  bus.err,              0);
            check_eq({tag, "_hdr_lerr"}, bus.len_err,          0);
            check_eq({tag, "_hdr_lpv"},  bus.low_packet_valid, 0);
            check_eq({tag, "_hdr_busy"}, bus.busy,             1);
        end
        foreach (pay_q[i]) send_byte(1'b1, pay_q[i]);
        send_byte(1'b0, par);

        if (addr < NP) begin
            exp_q.delete();
            exp_q.push_back(hdr);
            foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
            exp_q.push_back(par);
            finish_valid(tag, par != good, e_lerr);
        end else begin
            repeat (2) begin
                @(negedge clock);
                bus.pkt_valid = 1'b0;
                bus.fifo_full = 1'b0;
            end
            check_eq({tag, "_drop_wr"},   wr_q.size(),          0);
            check_eq({tag, "_drop_hv"},   hv_cnt,               0);
            check_eq({tag, "_drop_pd"},   bus.parity_done,      exp_pd);
            check_eq({tag, "_drop_err"},  bus.err,              exp_err);
            check_eq({tag, "_drop_lerr"}, bus.len_err,          exp_lerr);
            check_eq({tag, "_drop_lpv"},  bus.low_packet_valid, exp_lpv);
            check_eq({tag, "_drop_addr"}, bus.dest_addr,        exp_addr);
        end
    endtask

    task automatic fill_random(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(DW'($urandom));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.pkt_valid = 1'b0;
        bus.data_in   = '0;
        bus.fifo_full = 1'b0;
        rand_full = 1'b0;
        exp_pd = 0; exp_err = 0; exp_lerr = 0; exp_lpv = 0; exp_addr = '0;
        hv_cnt = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        pay_q = '{8'h11, 8'h22, 8'h33};
        run_packet("good", 1, 3, -1);
        run_packet("badpar", 1, 3, 8'hFF);
        run_packet("clear", 1, 3, -1);

        // Back-pressure on payload byte 22 for three cycles
        wr_q.delete();
        hv_cnt = 0;
        exp_addr = 2'd1;
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        @(negedge clock);
        bus.pkt_valid = 1'b1; bus.data_in = 8'h22; bus.fifo_full = 1'b1;
        check_eq("hold_enter_busy", bus.busy, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            bus.data_in = 8'h33; bus.fifo_full = 1'b1;
            check_eq("hold_busy", bus.busy, 1);
            check_eq("hold_nowr", bus.write_enb, 0);
        end
        @(negedge clock);
        bus.fifo_full = 1'b0;
        check_eq("hold_busy_last", bus.busy, 1);
        check_eq("hold_nowr_last", bus.write_enb, 0);
        @(negedge clock);
        check_eq("hold_rel_busy", bus.busy, 0);
        check_eq("hold_rel_wen", bus.write_enb, 1);
        check_eq("hold_rel_data", bus.data_out, 8'h22);
        @(posedge clock);
        send_byte(1'b0, 8'h0D);
        exp_q = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};
        finish_valid("hold", 1'b0, 1'b0);

        pay_q = '{8'hAA, 8'hBB};
        run_packet("drop", 3, 1, -1);
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_packet("after_drop", 1, 3, -1);

        pay_q = '{8'h11, 8'h22};
        run_packet("short", 1, 3, -1);
        pay_q.delete();
        run_packet("zero_len", 2, 0, -1);
        fill_random(70);
        run_packet("saturate", 0, MAXLEN, -1);

        rand_full = 1'b1;
        for (int p = 0; p < 24; p++) begin
            int a, l, n;
            a = $urandom_range(0, 3);
            l = $urandom_range(0, 10);
            n = l + $urandom_range(0, 2) - 1;
            if (n < 0) n = 0;
            fill_random(n);
            run_packet("rand", a, l, ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : -1);
        end
        rand_full = 1'b0;

        // Reset in the middle of a payload
        send_byte(1'b1, 8'h0D);
        send_byte(1'b1, 8'h11);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check_all_zero("midreset");
        reset = 1'b0;
        bus.pkt_valid = 1'b0;
        exp_pd = 0; exp_err = 0; exp_lerr = 0; exp_lpv = 0; exp_addr = '0;
        pay_q = '{8'h11, 8'h22, 8'h33};
        run_packet("post_reset", 1, 3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/router_reg_param.md
Name: router_reg_param

Overview:
- Parametrised packet register stage between the router input and the per-destination FIFOs; next generation of the router's datapath register.
- Contains its own packet FSM, header decode, one-entry hold register for FIFO back-pressure, running parity, and error flags.
- Generalised in data width and port count; adds an upstream stall, an invalid-address drop, and an optional length check.

Parameters:
- DATA_WIDTH, 8, byte width; header = {len[DATA_WIDTH-1:ADDR_BITS], addr[ADDR_BITS-1:0]}
- ADDR_BITS, 2, width of the destination address field
- NUM_PORTS, 3, number of valid destinations; addr >= NUM_PORTS is invalid

Ports:
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- pkt_valid  in  1  high for header and payload; low with the parity byte
- data_in  in  DATA_WIDTH  packet byte
- fifo_full  in  1  selected destination FIFO is full
- busy  out  1  upstream must hold data_in/pkt_valid unchanged while high
- data_out  out  DATA_WIDTH  byte to FIFO
- write_enb  out  1  data_out valid this cycle
- dest_addr  out  ADDR_BITS  captured header address
- header_valid  out  1  one-cycle pulse after a valid header is captured
- parity_done  out  1  packet check complete
- err  out  1  parity mismatch
- len_err  out  1  payload count differs from header length
- low_packet_valid  out  1  parity byte received

Behaviour:
- Reset (sync, high, dominates all events): all outputs 0, FSM to IDLE, parity/count/hold cleared.
- States: IDLE, LOAD_FIRST, LOAD_DATA, HOLD, CHECK, DROP.
- IDLE: busy=0. pkt_valid=1 with addr<NUM_PORTS: capture header and dest_addr; clear parity_done, err, len_err, low_packet_valid; header_valid=1 next cycle; go to LOAD_FIRST. pkt_valid=1 with addr>=NUM_PORTS: go to DROP, no write. Otherwise stay.
- LOAD_FIRST: data_out<=header, write_enb=1, internal_parity<=header; busy=1; go to LOAD_DATA.
- LOAD_DATA: busy=0.
  - fifo_full=1: copy data_in into the hold register, remember whether it is the parity byte (pkt_valid=0); go to HOLD; no write.
  - Else if pkt_valid=1: data_out<=data_in, write_enb=1, internal_parity^=data_in, count++ (count saturates at all-ones).
  - Else (parity byte): data_out<=data_in, write_enb=1, packet_parity<=data_in, low_packet_valid=1; go to CHECK.
- HOLD: busy=1; no write while fifo_full=1. When fifo_full=0, write the held byte (write_enb=1).
  - Payload byte: XOR into parity, count++, return to LOAD_DATA.
  - Parity byte: set packet_parity and low_packet_valid, go to CHECK.
- CHECK: busy=1, one cycle. parity_done<=1; err<=(internal_parity!=packet_parity); len_err per the optional feature; go to IDLE.
- parity_done, err, len_err and low_packet_valid hold until the next valid header is accepted.
- DROP: busy=0, no writes; remain until pkt_valid is sampled low (that byte is consumed), then go to IDLE. No flags change.
- Latency: data_in to data_out is 1 cycle when not full; header write occurs 1 cycle after capture.
- A zero-length header is legal: the next byte must be the parity byte.

Optional Feature:
- ROUTER_REG_LEN_CHECK_EN defined: payload counter present; in CHECK, len_err<=(count!=len).
- Not defined: counter removed; len_err tied to 0.

Test Plan:
- 8-bit, header 8'h0D (len=3, addr=1), payload 11,22,33, parity 0D^11^22^33=8'h0D, fifo_full=0 -> writes 0D,11,22,33,0D on consecutive cycles after the 1-cycle header; header_valid pulse; dest_addr=1; parity_done=1, err=0, len_err=0.
- Same packet with parity 8'hFF -> err=1, parity_done=1; both clear on the next valid header.
- Header 8'h0D, fifo_full=1 for 3 cycles while payload byte 22 is presented -> 22 held, busy=1 for 3 cycles, no write, then 22 written once with busy=0; parity is still correct.
- Header 8'h07 (addr=3 invalid), 2 bytes, then pkt_valid low -> no write_enb, no flags, back in IDLE; the next valid packet processes normally.
- With ROUTER_REG_LEN_CHECK_EN: header len=3, only 2 payload bytes before parity -> len_err=1. Without the macro, same stimulus -> len_err=0.
- reset=1 asserted mid-payload -> next cycle all outputs 0, FSM in IDLE; a fresh packet afterwards checks cleanly.
